// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
// Holds FSM state, funct3 encodings, byte-enable patterns and a size decode helper.
package load_store_unit_pkg;

    typedef logic       enable_t;
    typedef logic [2:0] funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP
    } lsu_state_t;

    typedef enum logic [2:0] {
        FUNCT3_LB  = 3'b000,
        FUNCT3_LH  = 3'b001,
        FUNCT3_LW  = 3'b010,
        FUNCT3_LBU = 3'b100,
        FUNCT3_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        FUNCT3_SB = 3'b000,
        FUNCT3_SH = 3'b001,
        FUNCT3_SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // funct3[2] only selects sign; undefined widths behave as word.
    function automatic access_size_t access_size(input funct3_t f3);
        case (f3[1:0])
            2'b00:   access_size = SZ_BYTE;
            2'b01:   access_size = SZ_HALF;
            default: access_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatter: selects the addressed byte/half of the raw word
// and sign/zero-extends it. Ports: raw_word, offset, funct3 in; data out.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  offset,
    input  funct3_t     funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw_word[{offset, 3'b000} +: 8];
        half_sel = raw_word[{offset[1], 4'b0000} +: 16];
        data     = raw_word;
        case (funct3)
            FUNCT3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            FUNCT3_LBU: data = {24'h0, byte_sel};
            FUNCT3_LH:  data = {{16{half_sel[15]}}, half_sel};
            FUNCT3_LHU: data = {16'h0, half_sel};
            default:    data = raw_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/gnt/rvalid transaction per load or store,
// with byte enables, store lane replication, load extension and pipeline stall.
// Ports: pipeline controls (mem_read_c_i, mem_write_c_i, funct3_i, addr_i, wdata_i),
// pipeline results (stall_o, rdata_o, ld_done_o, misaligned_o),
// memory port (req_o, we_o, addr_o, be_o, wdata_o, gnt_i, rvalid_i, rdata_i).
// Build option: LSU_MISALIGN_TRAP_EN rejects misaligned accesses instead of
// truncating the offset to natural alignment.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MEM_LAT_MIN = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  enable_t           mem_read_c_i,
    input  enable_t           mem_write_c_i,
    input  funct3_t           funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              ld_done_o,
    output logic              misaligned_o,
    output logic              req_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [3:0]        be_o,
    output logic [31:0]       wdata_o,
    input  logic              gnt_i,
    input  logic              rvalid_i,
    input  logic [31:0]       rdata_i
);

    lsu_state_t   state, state_nxt;
    logic         we_q;
    funct3_t      funct3_q;
    logic [1:0]   off_q;

    logic         access;
    access_size_t size;
    logic [1:0]   off;
    logic [3:0]   be_nxt;
    logic [31:0]  wdata_nxt;
    logic         misaligned;
    logic         mis_pulse;
    logic         capture;
    logic [31:0]  load_data;

    lsu_load_align u_align (
        .raw_word (rdata_i),
        .offset   (off_q),
        .funct3   (funct3_q),
        .data     (load_data)
    );

    always_comb begin
        access = mem_read_c_i | mem_write_c_i;
        size   = access_size(funct3_i);
        off    = addr_i[1:0];
        if (size == SZ_HALF) off = {addr_i[1], 1'b0};
        if (size == SZ_WORD) off = 2'b00;

        be_nxt    = BE_WORD;
        wdata_nxt = wdata_i;
        if (!mem_read_c_i) begin
            case (size)
                SZ_BYTE: begin
                    be_nxt    = BE_BYTE << off;
                    wdata_nxt = {4{wdata_i[7:0]}};
                end
                SZ_HALF: begin
                    be_nxt    = BE_HALF << off;
                    wdata_nxt = {2{wdata_i[15:0]}};
                end
                default: begin
                    be_nxt    = BE_WORD;
                    wdata_nxt = wdata_i;
                end
            endcase
        end

`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = (size == SZ_HALF && addr_i[0])
                   || (size == SZ_WORD && addr_i[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Set after the trap cycle so the held instruction retires next cycle.
    logic mis_q;
`endif

    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        req_o     = 1'b0;
        ld_done_o = 1'b0;
        mis_pulse = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    stall_o   = 1'b1;
                    capture   = 1'b1;
                    state_nxt = ADDR;
                end
`ifdef LSU_MISALIGN_TRAP_EN
                else if (access && !mis_q) begin
                    stall_o   = 1'b1;
                    mis_pulse = 1'b1;
                end
`endif
            end
            ADDR: begin
                req_o   = 1'b1;
                stall_o = 1'b1;
                if (gnt_i) begin
                    if (we_q) begin
                        stall_o   = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                stall_o = 1'b1;
                if (rvalid_i) begin
                    stall_o   = 1'b0;
                    ld_done_o = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        misaligned_o = mis_pulse;
        we_o         = req_o & we_q;
        rdata_o      = ld_done_o ? load_data : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            addr_o   <= '0;
            be_o     <= 4'h0;
            wdata_o  <= 32'h0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
        end else begin
            state <= state_nxt;
            if (capture) begin
                we_q     <= ~mem_read_c_i;
                addr_o   <= {addr_i[ADDR_W-1:2], 2'b00};
                be_o     <= be_nxt;
                wdata_o  <= wdata_nxt;
                funct3_q <= funct3_i;
                off_q    <= off;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) mis_q <= 1'b0;
        else         mis_q <= mis_pulse;
    end
`endif

    // Memory never answers a read in its own grant cycle.
    always_ff @(posedge clk_i) begin
        if (rst_ni && state == ADDR && gnt_i && !we_q)
            assert (MEM_LAT_MIN >= 1 && !rvalid_i);
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: randomized and directed accesses,
// expected requests and load results queued by a reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mem_read_c_i = 1'b0;
    logic        mem_write_c_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        stall_o, ld_done_o, misaligned_o;
    logic [31:0] rdata_o;
    logic        req_o, we_o;
    logic [31:0] addr_o;
    logic [3:0]  be_o;
    logic [31:0] wdata_o;
    logic        gnt_i = 1'b0;
    logic        rvalid_i = 1'b0;
    logic [31:0] rdata_i = 32'h0;

    int vectors = 0;
    int errors  = 0;
    int mis_exp = 0;
    int mis_seen = 0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_load[$];

    load_store_unit #(.ADDR_W(32), .MEM_LAT_MIN(1)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .mem_read_c_i  (mem_read_c_i),
        .mem_write_c_i (mem_write_c_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .ld_done_o     (ld_done_o),
        .misaligned_o  (misaligned_o),
        .req_o         (req_o),
        .we_o          (we_o),
        .addr_o        (addr_o),
        .be_o          (be_o),
        .wdata_o       (wdata_o),
        .gnt_i         (gnt_i),
        .rvalid_i      (rvalid_i),
        .rdata_i       (rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0] f3,
                                             input logic [31:0] word,
                                             input int eff);
        int nb;
        logic [31:0] val, mask;
        nb  = nbytes(f3);
        val = word >> (8 * eff);
        if (nb < 4) begin
            mask = (32'h1 << (8 * nb)) - 32'h1;
            val  = val & mask;
            if (!f3[2] && val[8*nb-1]) val = val | ~mask;
        end
        return val;
    endfunction

    // Monitor: compare every granted request and completed load in order.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (req_o && gnt_i) begin
                if (exp_req.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %h expected none", addr_o);
                end else begin
                    req_t e;
                    e = exp_req.pop_front();
                    check("req_addr", addr_o, e.addr);
                    check("req_we", {31'h0, we_o}, {31'h0, e.we});
                    check("req_be", {28'h0, be_o}, {28'h0, e.be});
                    if (e.we) check("req_wdata", wdata_o, e.wdata);
                end
            end
            if (ld_done_o) begin
                if (exp_load.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_ld_done: got %h expected none", rdata_o);
                end else begin
                    check("load_data", rdata_o, exp_load.pop_front());
                end
            end
            if (misaligned_o) mis_seen++;
        end
    end

    task automatic run_access(input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] word,
                              input int gd, input int rl);
        int nb, eff, exp_cyc, cyc_done, gcnt, rcnt;
        logic acc, misal, trap, done, resp, gnt_prev;
        req_t r;
        nb    = nbytes(f3);
        acc   = rd | wr;
        misal = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
        trap  = TRAP_EN && acc && misal;
        eff   = int'(addr[1:0]) - (int'(addr[1:0]) % nb);
        if (acc && !trap) begin
            r.addr  = addr & ~32'h3;
            r.we    = !rd;
            r.be    = rd ? 4'hF : 4'((((1 << nb) - 1) << eff) & 15);
            r.wdata = 32'h0;
            for (int i = 0; i < 4; i++)
                r.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
            exp_req.push_back(r);
            if (rd) exp_load.push_back(fmt_load(f3, word, eff));
        end
        if (trap) mis_exp++;
        if (!acc)      exp_cyc = 0;
        else if (trap) exp_cyc = 1;
        else if (rd)   exp_cyc = 1 + gd + rl;
        else           exp_cyc = 1 + gd;

        mem_read_c_i  = rd;
        mem_write_c_i = wr;
        funct3_i      = f3;
        addr_i        = addr;
        wdata_i       = wd;
        done = 0; resp = 0; gnt_prev = 0;
        gcnt = 0; rcnt = 0; cyc_done = -1;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (gnt_prev && rd) begin
                resp = 1;
                rcnt = 0;
            end
            if (resp) rcnt++;
            gnt_i = req_o && (gcnt == gd);
            if (req_o) gcnt++;
            rvalid_i = resp && (rcnt == rl);
            rdata_i  = rvalid_i ? word : $urandom;
            @(negedge clk);
            check("misaligned_o", {31'h0, misaligned_o},
                  {31'h0, (trap && cyc == 0)});
            if (!stall_o) begin
                done     = 1;
                cyc_done = cyc;
            end
            gnt_prev = gnt_i;
            @(posedge clk);
            #1;
        end
        check("latency", cyc_done, exp_cyc);
        mem_read_c_i  = 1'b0;
        mem_write_c_i = 1'b0;
        gnt_i         = 1'b0;
        rvalid_i      = 1'b0;
    endtask

    initial begin
        int gcnt;
        logic in_resp;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {27'h0, stall_o, req_o, we_o, ld_done_o, misaligned_o}, 32'h0);
        check("reset_addr", addr_o, 32'h0);
        check("reset_be", {28'h0, be_o}, 32'h0);
        check("reset_wdata", wdata_o, 32'h0);
        check("reset_rdata", rdata_o, 32'h0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        run_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1);
        run_access(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 1);
        run_access(1, 0, 3'b000, 32'h102, 32'h0, 32'h1280FF34, 0, 2);
        run_access(1, 0, 3'b101, 32'h102, 32'h0, 32'h1280FF34, 2, 1);
        run_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h1280FF34, 0, 3);
        run_access(1, 0, 3'b001, 32'h202, 32'h0, 32'h80001234, 0, 1);
        run_access(1, 1, 3'b100, 32'h301, 32'h0, 32'h0000C300, 1, 1);
        run_access(1, 0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 1);
        run_access(0, 1, 3'b001, 32'h101, 32'h00001234, 32'h0, 0, 1);
        run_access(0, 0, 3'b010, 32'h104, 32'h0, 32'h0, 0, 1);

        // Reset while a load waits in RESP, then a stale response.
        mem_read_c_i = 1'b1;
        funct3_i     = 3'b010;
        addr_i       = 32'h300;
        exp_req.push_back('{32'h300, 1'b0, 4'hF, 32'h0});
        gcnt    = 0;
        in_resp = 0;
        for (int cyc = 0; cyc < 20 && !in_resp; cyc++) begin
            gnt_i = req_o && (gcnt == 3);
            if (req_o) gcnt++;
            @(negedge clk);
            if (gnt_i) in_resp = 1;
            @(posedge clk);
            #1;
        end
        gnt_i = 1'b0;
        check("reach_resp", {31'h0, in_resp}, 32'h1);
        @(negedge clk);
        check("resp_stall", {30'h0, stall_o, req_o}, 32'h2);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        mem_read_c_i = 1'b0;
        @(negedge clk);
        check("rst_mid", {29'h0, req_o, stall_o, ld_done_o}, 32'h0);
        @(posedge clk);
        #1;
        rst_ni   = 1'b1;
        rvalid_i = 1'b1;
        rdata_i  = 32'h55AA55AA;
        repeat (2) begin
            @(negedge clk);
            check("stale_rvalid", {30'h0, ld_done_o, stall_o}, 32'h0);
            @(posedge clk);
            #1;
        end
        rvalid_i = 1'b0;
        run_access(1, 0, 3'b100, 32'h403, 32'h0, 32'h9A000000, 0, 1);

        for (int n = 0; n < 150; n++) begin
            int sel;
            logic rd, wr;
            sel = $urandom_range(0, 7);
            rd  = (sel >= 1 && sel <= 4);
            wr  = (sel == 1 || sel >= 5);
            run_access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
                       $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
        end

        repeat (2) @(posedge clk);
        check("req_queue_empty", exp_req.size(), 32'h0);
        check("load_queue_empty", exp_load.size(), 32'h0);
        check("misaligned_count", mis_seen, mis_exp);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage consumer of the decoder's mem_read/mem_write controls for the 5-stage RV32I core.
- Turns one load or store per instruction into a request/grant/response transaction on the data-memory port.
- Generates byte enables and store-data lane replication, extracts and extends load data, and stalls the pipeline until the access completes.

Parameters:
ADDR_W, 32, byte-address width on both the pipeline and memory sides.
MEM_LAT_MIN, 1, minimum gnt-to-rvalid distance guaranteed by memory (>=1); documentation/assertion only.

Ports:
clk_i  in  1  core clock.
rst_ni  in  1  synchronous active-low reset.
mem_read_c_i  in  enable_t  load requested by the instruction in MEM.
mem_write_c_i  in  enable_t  store requested by the instruction in MEM.
funct3_i  in  funct3_t  access width/sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
addr_i  in  ADDR_W  effective address (ALU result).
wdata_i  in  32  store data (rs2).
stall_o  out  1  hold the pipeline; inputs stay stable while high.
rdata_o  out  32  formatted load data; valid only while ld_done_o is high.
ld_done_o  out  1  one-cycle pulse: load complete.
misaligned_o  out  1  one-cycle pulse: misaligned access rejected (feature only).
req_o  out  1  memory request.
we_o  out  1  1 = write.
addr_o  out  ADDR_W  word-aligned address, bits [1:0] = 0.
be_o  out  4  byte enables.
wdata_o  out  32  lane-replicated store data.
gnt_i  in  1  request accepted this cycle.
rvalid_i  in  1  read response valid.
rdata_i  in  32  raw read word.

Behaviour:
- Reset (rst_ni low at a clock edge): state IDLE; req_o, we_o, ld_done_o, misaligned_o, stall_o = 0; addr_o, be_o, wdata_o, rdata_o = 0.
- FSM states: IDLE, ADDR, RESP.
- Access present in IDLE = mem_read_c_i | mem_write_c_i. If both are high, the read wins and the write is ignored.
- IDLE + access: stall_o = 1 combinationally.
  - Next edge: register we, addr_o = {addr_i[ADDR_W-1:2], 2'b00}, be_o, wdata_o, funct3, addr_i[1:0]; go to ADDR.
- ADDR: req_o = 1; outputs held until gnt_i.
  - gnt_i with we: go to IDLE; stall_o = 0 in the gnt cycle, so the store retires.
  - gnt_i with read: go to RESP; stall_o stays 1.
- RESP: stall_o = 1 until rvalid_i.
  - rvalid_i cycle: rdata_o = formatted rdata_i (combinational), ld_done_o = 1, stall_o = 0; next edge go to IDLE.
- rvalid_i outside RESP is ignored, including a stale response after a mid-transaction reset.
- Minimum latencies:
  - Store: 2 cycles (1 stall cycle before the request + grant cycle).
  - Load: 3 cycles.
  - Back-to-back accesses: the next instruction's access starts in IDLE on the cycle after completion.
- Byte enables and store data:
  - SB: be = 4'b0001 << off; wdata = {4{wdata_i[7:0]}}.
  - SH: be = 4'b0011 << {off[1],1'b0}; wdata = {2{wdata_i[15:0]}}.
  - SW and any undefined funct3 (011, 110, 111): be = 4'b1111; wdata = wdata_i.
  - Loads always drive be = 4'b1111.
- Load formatting, using the registered off:
  - LB/LBU: select byte rdata_i[8*off +: 8], then sign- or zero-extend.
  - LH/LHU: select rdata_i[16*off[1] +: 16], then sign- or zero-extend.
  - LW and undefined funct3: pass rdata_i through.
- Reset mid-transaction (ADDR or RESP): go to IDLE and drop req_o in the same edge; no ld_done_o.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - An access is misaligned if (half and off[0]) or (word and off != 0).
  - A misaligned access in IDLE issues no request.
  - misaligned_o and stall_o pulse for one cycle; next cycle stall_o = 0 and the instruction retires with no memory effect and no ld_done_o.
- Undefined:
  - misaligned_o is tied 0.
  - Low offset bits are truncated to natural alignment: half uses off = {off[1],0}; word uses off = 0.

Decomposition:
- Shared package:
  - lsu_state_t {IDLE, ADDR, RESP}.
  - LOAD_FUNCT3 enum (FUNCT3_LB/LH/LW/LBU/LHU).
  - STORE_FUNCT3 enum (FUNCT3_SB/SH/SW).
  - BE_BYTE/BE_HALF/BE_WORD constants.
- One combinational sub-module: lsu_load_align.
  - Inputs: raw word, offset, funct3.
  - Output: extended data.
  - Unit-testable on its own.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt on first req cycle -> addr_o 0x100, be 1111, wdata 0xDEADBEEF; stall high 1 cycle, then low in the gnt cycle.
- SB addr 0x103, wdata 0x000000A5 -> be 1000, wdata_o 0xA5A5A5A5, addr_o 0x100.
- LB addr 0x102, rdata_i 0x1280FF34, rvalid 2 cycles after gnt -> rdata_o 0xFFFFFF80, ld_done 1 pulse; stall high until the rvalid cycle.
- LHU addr 0x102, same rdata -> 0x00001280; LH -> 0x00001280; LH on 0x8000 upper half -> 0xFFFF8000.
- gnt withheld 3 cycles, then rst_ni low in RESP, then a stray rvalid -> req_o/stall_o 0 after reset edge, no ld_done, FSM IDLE.
- LSU_MISALIGN_TRAP_EN: LW addr 0x101 -> no req_o, misaligned_o one pulse; without macro -> addr_o 0x100, be 1111, completes normally.
